// File: rtl/zx_tape_streamer.sv
// Tape image buffer and streamer for the ZX80/ZX81 core: captures a downloaded .o/.p image,
// then on the ROM LOAD trap copies it into main RAM over a req/ack port and flags completion.
`timescale 1ns/1ps
module zx_tape_streamer #(
  parameter int unsigned BUF_AW  = 14,
  parameter int unsigned RAM_AW  = 16,
  parameter logic [15:0] BASE_O  = 16'h4000,
  parameter logic [15:0] BASE_P  = 16'h4009,
  parameter logic [15:0] TRAP_LO = 16'h0347,
  parameter logic [15:0] TRAP_HI = 16'h03C3
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              img_wr,
  input  logic [24:0]       img_addr,
  input  logic [7:0]        img_data,
  input  logic              img_active,
  input  logic              img_type,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_m1_n,
  input  logic              cpu_ce,
  output logic              mem_req,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              loading,
  output logic              patch_scf,
  output logic              tape_ready,
  output logic              overflow,
  output logic [BUF_AW:0]   tape_size
);

  localparam int unsigned DEPTH = 2 ** BUF_AW;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Image length clamped to the buffer depth; a download with no writes is empty.
  function automatic logic [BUF_AW:0] sat_size(input logic [24:0] last, input logic any_wr);
    logic [BUF_AW:0] sz;
    if (!any_wr)
      sz = '0;
    else if (|last[24:BUF_AW])
      sz = {1'b1, {BUF_AW{1'b0}}};
    else
      sz = {1'b0, last[BUF_AW-1:0]} + (BUF_AW+1)'(1);
    return sz;
  endfunction

  logic              img_active_p1;
  logic              cpu_m1_n_p1;
  logic              ovf_pend;
  logic              got_wr;
  logic [24:0]       last_addr;
  logic              img_type_q;
  logic [2:0]        state;
  logic [BUF_AW:0]   idx;
  logic [7:0]        rd_data;
  logic [7:0]        buf_mem [DEPTH];

  logic              in_buf;
  logic              img_rise;
  logic              img_fall;
  logic              m1_start;
  logic              trap_hit;
  logic              win_exit;
  logic [15:0]       base;

  assign in_buf     = ~|img_addr[24:BUF_AW];
  assign img_rise   = ~img_active_p1 & img_active;
  assign img_fall   = img_active_p1 & ~img_active;
  assign m1_start   = cpu_m1_n_p1 & ~cpu_m1_n;
  assign trap_hit   = m1_start && (cpu_addr == TRAP_LO);
  assign win_exit   = m1_start && ((cpu_addr < TRAP_LO) || (cpu_addr >= TRAP_HI));
  assign base       = img_type_q ? BASE_P : BASE_O;
  assign tape_ready = |tape_size;

  // Stage p1: edge detectors and image capture bookkeeping
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      img_active_p1 <= 1'b0;
      cpu_m1_n_p1   <= 1'b1;
      ovf_pend      <= 1'b0;
      got_wr        <= 1'b0;
      last_addr     <= '0;
      img_type_q    <= 1'b0;
      overflow      <= 1'b0;
      tape_size     <= '0;
    end else begin
      img_active_p1 <= img_active;
      cpu_m1_n_p1   <= cpu_m1_n;
      if (img_wr)
        last_addr <= img_addr;
      if (img_rise)
        got_wr <= img_wr;
      else if (img_wr)
        got_wr <= 1'b1;
      if (img_fall) begin
        tape_size  <= sat_size(last_addr, got_wr);
        img_type_q <= img_type;
        overflow   <= ovf_pend;
        ovf_pend   <= 1'b0;
      end else if (img_wr && !in_buf) begin
        ovf_pend <= 1'b1;
      end
    end
  end

  // Buffer RAM: one write port for the download, one-cycle registered read for the streamer
  always_ff @(posedge clk_sys) begin
    if (img_wr && in_buf)
      buf_mem[img_addr[BUF_AW-1:0]] <= img_data;
    rd_data <= buf_mem[idx[BUF_AW-1:0]];
  end

  // Stage p2: streaming FSM; M1 trap/exit and download abort override the state step
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      loading   <= 1'b0;
      patch_scf <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (idx >= tape_size)
            state <= ST_DONE;
          else
            state <= ST_LATCH;
        end
        ST_LATCH: begin
          mem_data <= rd_data;
          mem_addr <= RAM_AW'(base) + RAM_AW'(idx);
          if (cpu_ce) begin
            mem_req <= 1'b1;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            idx     <= idx + (BUF_AW+1)'(1);
            state   <= ST_FETCH;
          end
        end
        ST_DONE: patch_scf <= 1'b1;
        default: ;
      endcase

      if (img_rise && (state != ST_IDLE)) begin
        state   <= ST_IDLE;
        mem_req <= 1'b0;
      end

      // A pending request is withdrawn on re-trap so the restart never carries a stale write
      if (trap_hit) begin
        idx       <= '0;
        patch_scf <= 1'b0;
        state     <= ST_FETCH;
        loading   <= 1'b1;
        mem_req   <= 1'b0;
      end else if (win_exit) begin
        state     <= ST_IDLE;
        loading   <= 1'b0;
        mem_req   <= 1'b0;
        patch_scf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zx_tape_streamer.sv
// Scoreboard bench for zx_tape_streamer: expected RAM writes are queued by the stimulus
// and popped by a monitor on every req/ack handshake.
`timescale 1ns/1ps
module tb_zx_tape_streamer;
  localparam int BUF_AW = 4;
  localparam int RAM_AW = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              img_wr = 1'b0;
  logic [24:0]       img_addr = '0;
  logic [7:0]        img_data = '0;
  logic              img_active = 1'b0;
  logic              img_type = 1'b0;
  logic [15:0]       cpu_addr = '0;
  logic              cpu_m1_n = 1'b1;
  logic              cpu_ce = 1'b0;
  logic              mem_req;
  logic [RAM_AW-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack = 1'b0;
  logic              loading;
  logic              patch_scf;
  logic              tape_ready;
  logic              overflow;
  logic [BUF_AW:0]   tape_size;

  zx_tape_streamer #(.BUF_AW(BUF_AW), .RAM_AW(RAM_AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .img_wr(img_wr), .img_addr(img_addr),
    .img_data(img_data), .img_active(img_active), .img_type(img_type),
    .cpu_addr(cpu_addr), .cpu_m1_n(cpu_m1_n), .cpu_ce(cpu_ce),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .loading(loading), .patch_scf(patch_scf), .tape_ready(tape_ready),
    .overflow(overflow), .tape_size(tape_size)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int req_rises = 0;
  int req_len = 0;
  int max_req_len = 0;
  logic [23:0] exp_q [$];
  logic ack_en = 1'b0;
  int ack_delay = 1;
  int stall_idx = -1;
  int stall_len = 0;
  int wcnt = 0;
  logic prev_req = 1'b0;
  logic [15:0] cap_addr = '0;
  logic [7:0]  cap_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every handshake pops one expected {addr,data}
  initial forever begin
    logic [23:0] e;
    @(negedge clk_sys);
    if (mem_req && !prev_req) begin
      req_rises++;
      cap_addr = mem_addr;
      cap_data = mem_data;
      req_len  = 0;
    end
    if (mem_req) begin
      req_len++;
      if (req_len > max_req_len) max_req_len = req_len;
    end
    if (mem_req && mem_ack) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("write_at_req", {8'h00, cap_addr, cap_data}, {8'h00, e});
        check("write_at_ack", {8'h00, mem_addr, mem_data}, {8'h00, e});
      end
    end
    prev_req = mem_req;
  end

  // RAM-side responder: one-cycle ack after a programmable delay
  initial forever begin
    int dly;
    @(posedge clk_sys); #1;
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && ack_en) begin
      dly = (writes == stall_idx) ? stall_len : ack_delay;
      if (wcnt >= dly) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  initial forever begin
    @(posedge clk_sys); #1;
    cpu_ce = ~cpu_ce;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic download(input int n, input logic [7:0] d0, input logic ty);
    tick();
    img_active = 1'b1;
    img_type = ty;
    for (int i = 0; i < n; i++) begin
      tick();
      img_wr = 1'b1;
      img_addr = 25'(i);
      img_data = d0 + 8'(i);
    end
    tick();
    img_wr = 1'b0;
    img_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic m1(input logic [15:0] a);
    tick();
    cpu_addr = a;
    cpu_m1_n = 1'b0;
    tick();
    tick();
    cpu_m1_n = 1'b1;
  endtask

  task automatic push_seq(input int n, input logic [15:0] b, input logic [7:0] d0);
    for (int i = 0; i < n; i++) exp_q.push_back({b + 16'(i), d0 + 8'(i)});
  endtask

  task automatic wait_writes(input int n, input string nm);
    for (int i = 0; i < 2000 && writes < n; i++) @(negedge clk_sys);
    check(nm, writes, n);
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (mem_req) break;
    end
    check(nm, mem_req, 1);
  endtask

  task automatic wait_scf(input string nm);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (patch_scf) break;
    end
    check(nm, patch_scf, 1);
  endtask

  initial begin
    int found;
    int rises0;
    repeat (3) tick();
    check("reset_async_outs", {mem_req, loading, patch_scf, tape_ready, overflow}, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_data", mem_data, 0);
    check("reset_tape_size", tape_size, 0);
    check("reset_flags", {mem_req, loading, patch_scf, tape_ready, overflow}, 0);

    // .p image, 16 bytes, exactly fills the buffer
    download(16, 8'h00, 1'b1);
    @(negedge clk_sys);
    check("p_tape_size", tape_size, 16);
    check("p_overflow", overflow, 0);
    check("p_tape_ready", tape_ready, 1);
    writes = 0;
    push_seq(16, 16'h4009, 8'h00);
    ack_en = 1'b1;
    m1(16'h0347);
    wait_scf("p_scf");
    check("p_writes", writes, 16);
    check("p_queue", exp_q.size(), 0);
    check("p_loading", loading, 1);
    m1(16'h03C3);
    @(negedge clk_sys);
    check("p_exit", {loading, patch_scf}, 0);

    // .o image with a long ack stall on the second byte
    download(3, 8'hA0, 1'b0);
    writes = 0;
    max_req_len = 0;
    stall_idx = 1;
    stall_len = 10;
    push_seq(3, 16'h4000, 8'hA0);
    m1(16'h0347);
    wait_scf("o_scf");
    check("o_writes", writes, 3);
    check("o_queue", exp_q.size(), 0);
    check("o_stall_held", (max_req_len >= 11), 1);
    stall_idx = -1;
    m1(16'h03C3);

    // 20-byte download into a 16-byte buffer
    download(20, 8'h40, 1'b0);
    @(negedge clk_sys);
    check("ovf_flag", overflow, 1);
    check("ovf_tape_size", tape_size, 16);
    writes = 0;
    push_seq(16, 16'h4000, 8'h40);
    m1(16'h0347);
    wait_scf("ovf_scf");
    check("ovf_writes", writes, 16);
    check("ovf_queue", exp_q.size(), 0);
    m1(16'h03C3);

    // Empty image
    download(0, 8'h00, 1'b1);
    @(negedge clk_sys);
    check("empty_size", tape_size, 0);
    check("empty_ready", tape_ready, 0);
    check("empty_ovf_cleared", overflow, 0);
    writes = 0;
    rises0 = req_rises;
    tick();
    cpu_addr = 16'h0347;
    cpu_m1_n = 1'b0;
    found = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_sys);
      if (patch_scf && found == 0) found = i;
    end
    check("empty_scf_latency", (found > 0 && found <= 4), 1);
    tick();
    cpu_m1_n = 1'b1;
    check("empty_no_req", req_rises - rises0, 0);
    check("empty_loading", loading, 1);
    m1(16'h03C3);
    @(negedge clk_sys);
    check("empty_exit", {loading, patch_scf}, 0);

    // Mid-load window exit at byte 5 of 10
    download(10, 8'h80, 1'b0);
    writes = 0;
    push_seq(5, 16'h4000, 8'h80);
    m1(16'h0347);
    wait_writes(5, "exit_writes");
    ack_en = 1'b0;
    wait_req("exit_pending_req");
    m1(16'h0100);
    @(negedge clk_sys);
    check("exit_req_drop", mem_req, 0);
    check("exit_loading", loading, 0);
    check("exit_queue", exp_q.size(), 0);

    // Re-trap mid-load restarts from byte 0
    writes = 0;
    push_seq(5, 16'h4000, 8'h80);
    ack_en = 1'b1;
    m1(16'h0347);
    wait_writes(5, "retrap_pre_writes");
    ack_en = 1'b0;
    wait_req("retrap_pending_req");
    check("retrap_pending_word", {mem_addr, mem_data}, {16'h4005, 8'h85});
    push_seq(10, 16'h4000, 8'h80);
    m1(16'h0347);
    writes = 0;
    ack_en = 1'b1;
    wait_scf("retrap_scf");
    check("retrap_writes", writes, 10);
    check("retrap_queue", exp_q.size(), 0);
    m1(16'h03C3);

    // Asynchronous reset mid-transfer
    writes = 0;
    push_seq(5, 16'h4000, 8'h80);
    m1(16'h0347);
    wait_writes(5, "rst_pre_writes");
    ack_en = 1'b0;
    wait_req("rst_pending_req");
    check("rst_loading_before", loading, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_flags", {mem_req, loading, patch_scf, tape_ready, overflow}, 0);
    check("rst_mem_word", {mem_addr, mem_data}, 0);
    check("rst_tape_size", tape_size, 0);
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_queue", exp_q.size(), 0);

    // New download arriving mid-load aborts streaming
    download(10, 8'hC0, 1'b0);
    writes = 0;
    push_seq(3, 16'h4000, 8'hC0);
    ack_en = 1'b1;
    m1(16'h0347);
    wait_writes(3, "abort_pre_writes");
    ack_en = 1'b0;
    wait_req("abort_pending_req");
    rises0 = req_rises;
    download(7, 8'h10, 1'b1);
    @(negedge clk_sys);
    check("abort_req_drop", mem_req, 0);
    ack_en = 1'b1;
    repeat (20) tick();
    check("abort_no_new_req", req_rises - rises0, 0);
    check("abort_writes", writes, 3);
    check("abort_new_size", tape_size, 7);
    check("abort_queue", exp_q.size(), 0);
    m1(16'h03C3);
    @(negedge clk_sys);
    check("abort_exit", {loading, patch_scf, mem_req}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
